// File: rtl/hex_message_scroller_if.sv
// Interface bundling the message-write, run-control and display signals of the
// HEX marquee scroller. The controller side (board logic or bench) uses the
// master modport; the scroller itself uses the slave modport.
interface hex_message_scroller_if #(
    parameter int NUM_DIGITS = 6
);
    logic                      wr_en;
    logic [3:0]                wr_addr;
    logic [3:0]                wr_data;
    logic [4:0]                msg_len;
    logic                      start;
    logic                      stop;
    logic                      pause;
    logic                      busy;
    logic                      wrap;
    logic [NUM_DIGITS*4-1:0]   digit_codes;

    modport master (
        output wr_en, wr_addr, wr_data, msg_len, start, stop, pause,
        input  busy, wrap, digit_codes
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len, start, stop, pause,
        output busy, wrap, digit_codes
    );
endinterface

// File: rtl/hex_message_scroller.sv
// Right-to-left scrolling marquee across the HEX digits. A small message buffer
// is written while idle; once started, every TICK_DIV cycles the digit row
// shifts one place left and the next message character (or blank padding)
// enters on HEX0. The sequence length is len + NUM_DIGITS steps and repeats.
module hex_message_scroller #(
    parameter int         TICK_DIV   = 25000000,
    parameter int         MSG_DEPTH  = 16,
    parameter int         NUM_DIGITS = 6,
    parameter logic [3:0] BLANK_CODE = 4'h0
) (
    input logic                    clk,
    input logic                    reset,
    hex_message_scroller_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCROLL = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = NUM_DIGITS * 4;

    // One bit per possible wr_addr value, set where the address lands in the buffer.
    localparam logic [15:0] ADDR_OK = 16'((33'd1 << MSG_DEPTH) - 33'd1);

    logic [1:0]    state;
    logic [CW-1:0] prescaler;
    logic [PW-1:0] pos;
    logic [LW-1:0] len;
    logic [3:0]    buffer [MSG_DEPTH];
    logic [DW-1:0] digits;
    logic          busy_q;
    logic          wrap_q;

    logic          tick;
    logic          pos_last;
    logic          start_ok;
    logic          wr_ok;
    logic [3:0]    step_char;
    logic [LW-1:0] len_clamped;

    // Decode the tick, end-of-sequence, accepted start/write and the entering character.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        tick        = (prescaler == CW'(TICK_DIV - 1));
        pos_last    = (pos == PW'(len) + PW'(NUM_DIGITS - 1));
        start_ok    = bus.start && (bus.msg_len != 5'd0) && !bus.stop;
        wr_ok       = bus.wr_en && ADDR_OK[bus.wr_addr];
        len_clamped = (bus.msg_len > 5'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : LW'(bus.msg_len);
        step_char   = BLANK_CODE;
        if (pos < PW'(len)) begin
            step_char = buffer[pos[AW-1:0]];
        end
    end

    // Message buffer: written only while idle, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the buffer is reset because a cleared message is visible behaviour; this keeps it in flops, not RAM.
            for (int i = 0; i < MSG_DEPTH; i++) begin
                buffer[i] <= BLANK_CODE;
            end
        end else if ((state == ST_IDLE) && wr_ok) begin
            buffer[bus.wr_addr[AW-1:0]] <= bus.wr_data;
        end
    end

    // Run control, prescaler and digit shift register; stop beats pause beats tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
            prescaler <= '0;
            pos       <= '0;
            len       <= '0;
            digits    <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values; wrap defaults low to form a pulse.
            wrap_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_SCROLL;
                        busy_q    <= 1'b1;
                        len       <= len_clamped;
                        pos       <= '0;
                        prescaler <= '0;
                        digits    <= {NUM_DIGITS{BLANK_CODE}};
                    end
                end
                default: begin
                    if (bus.stop) begin
                        state     <= ST_IDLE;
                        busy_q    <= 1'b0;
                        pos       <= '0;
                        prescaler <= '0;
                        digits    <= {NUM_DIGITS{BLANK_CODE}};
                    end else if (bus.pause) begin
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_SCROLL;
                        if (tick) begin
                            prescaler <= '0;
                            digits    <= {digits[DW-5:0], step_char};
                            pos       <= pos_last ? '0 : pos + PW'(1);
                            wrap_q    <= pos_last;
                        end else begin
                            prescaler <= prescaler + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.wrap        = wrap_q;
    assign bus.digit_codes = digits;
endmodule

// File: tb/tb_hex_message_scroller.sv
// Bench for the HEX marquee scroller. A behavioural model derives the expected
// display from the count of un-paused cycles since start: step s shows message
// position (s-1-k) mod (len+6) on HEX k. Directed literals pin the model.
module tb_hex_message_scroller;
    localparam int TD = 4;
    localparam int ND = 6;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    hex_message_scroller_if #(.NUM_DIGITS(ND)) bus ();

    hex_message_scroller #(
        .TICK_DIV   (TD),
        .MSG_DEPTH  (16),
        .NUM_DIGITS (ND),
        .BLANK_CODE (4'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state.
    bit         m_run;
    bit         m_wrap;
    int         m_cnt;
    int         m_len;
    logic [3:0] m_buf [16];

    // Model update from the inputs present at each clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run  = 1'b0;
            m_wrap = 1'b0;
            m_cnt  = 0;
            m_len  = 0;
            for (int i = 0; i < 16; i++) m_buf[i] = 4'h0;
        end else begin
            m_wrap = 1'b0;
            if (!m_run) begin
                if (bus.wr_en) m_buf[bus.wr_addr] = bus.wr_data;
                if (bus.start && bus.msg_len != 5'd0 && !bus.stop) begin
                    m_run = 1'b1;
                    m_cnt = 0;
                    m_len = (int'(bus.msg_len) > 16) ? 16 : int'(bus.msg_len);
                end
            end else if (bus.stop) begin
                m_run = 1'b0;
            end else if (!bus.pause) begin
                m_cnt++;
                if ((m_cnt % TD == 0) && ((m_cnt / TD) % (m_len + ND) == 0)) m_wrap = 1'b1;
            end
        end
    end

    function automatic logic [23:0] exp_digits();
        logic [23:0] d;
        int s;
        int idx;
        d = 24'h0;
        if (m_run) begin
            s = m_cnt / TD;
            for (int k = 0; k < ND; k++) begin
                idx = s - 1 - k;
                if (idx >= 0) begin
                    idx = idx % (m_len + ND);
                    if (idx < m_len) d[k*4 +: 4] = m_buf[idx];
                end
            end
        end
        return d;
    endfunction

    // Compare DUT outputs with the model every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("model_busy", 32'(bus.busy), 32'(m_run));
            check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
            check("model_digits", 32'(bus.digit_codes), 32'(exp_digits()));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [3:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        bus.msg_len = len;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_digits"}, 32'(bus.digit_codes), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_wrap"}, 32'(bus.wrap), 32'h0);
        wait_cycles(2);
        reset = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'h0;
        bus.wr_data = 4'h0;
        bus.msg_len = 5'd0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pause   = 1'b0;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);
        check("reset_digits", 32'(bus.digit_codes), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);

        // Basic scroll of a three-character message.
        wr(4'd0, 4'h9);
        wr(4'd1, 4'hA);
        wr(4'd2, 4'hB);
        do_start(5'd3);
        check("start_busy", 32'(bus.busy), 32'h1);
        wait_cycles(4);
        check("step1", 32'(bus.digit_codes), 32'h000009);
        wait_cycles(4);
        check("step2", 32'(bus.digit_codes), 32'h00009A);
        wait_cycles(4);
        check("step3", 32'(bus.digit_codes), 32'h0009AB);
        wait_cycles(23);
        check("prewrap", 32'(bus.wrap), 32'h0);
        wait_cycles(1);
        check("wrap_pulse", 32'(bus.wrap), 32'h1);
        check("step9", 32'(bus.digit_codes), 32'h000000);
        wait_cycles(4);
        check("step10", 32'(bus.digit_codes), 32'h000009);
        check("postwrap", 32'(bus.wrap), 32'h0);

        // Pause two cycles into a tick period, hold for ten cycles.
        wait_cycles(2);
        bus.pause = 1'b1;
        wait_cycles(10);
        check("pause_digits", 32'(bus.digit_codes), 32'h000009);
        check("pause_busy", 32'(bus.busy), 32'h1);
        bus.pause = 1'b0;
        wait_cycles(1);
        check("resume1", 32'(bus.digit_codes), 32'h000009);
        wait_cycles(1);
        check("resume2", 32'(bus.digit_codes), 32'h00009A);

        // Stop and pause together.
        bus.stop  = 1'b1;
        bus.pause = 1'b1;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        check("stop_busy", 32'(bus.busy), 32'h0);
        check("stop_digits", 32'(bus.digit_codes), 32'h0);
        check("stop_wrap", 32'(bus.wrap), 32'h0);

        // Length edges.
        do_start(5'd0);
        check("len0_busy", 32'(bus.busy), 32'h0);
        do_start(5'd20);
        wait_cycles(87);
        check("len20_prewrap", 32'(bus.wrap), 32'h0);
        wait_cycles(1);
        check("len20_wrap", 32'(bus.wrap), 32'h1);
        do_start(5'd1);
        check("restart_ignored_busy", 32'(bus.busy), 32'h1);
        wait_cycles(3);
        check("len20_step23", 32'(bus.digit_codes), 32'h000009);

        // Write while scrolling is ignored; buffer survives stop/start.
        wr(4'd0, 4'hF);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        do_start(5'd3);
        wait_cycles(4);
        check("persist_step1", 32'(bus.digit_codes), 32'h000009);
        wait_cycles(2);
        async_reset_check("midscroll_reset");

        // Write and start in the same cycle after the buffer was cleared.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd0;
        bus.wr_data = 4'h5;
        bus.msg_len = 5'd3;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        bus.start   = 1'b0;
        wait_cycles(4);
        check("cleared_step1", 32'(bus.digit_codes), 32'h000005);
        wait_cycles(8);
        check("cleared_step3", 32'(bus.digit_codes), 32'h000500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
